// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: one outstanding access, lane-aligned bus, sign/zero-extending loads.
// Optional macro LSU_BUS_TIMEOUT_EN adds a MAX_WAIT-cycle handshake timeout that raises an access fault.
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef REG_BUS_A
`define REG_BUS_A 4:0
`endif
`ifndef REG_BUS_D
`define REG_BUS_D 31:0
`endif

module lsu_bus_ctrl #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk_i,
  input  logic                  rs_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [`AluOpBus]      uop_i,
  input  logic [DATA_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [`REG_BUS_A]     rd_wa_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [DATA_W-1:0]     bus_addr_o,
  output logic [DATA_W/8-1:0]   bus_sel_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic                  bus_err_i,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  output logic                  rsp_valid_o,
  output logic                  rd_we_o,
  output logic [`REG_BUS_A]     rd_wa_o,
  output logic [DATA_W-1:0]     rd_wd_o,
  output logic [`REG_BUS_D]     exception_o,
  output logic                  stall_req_o
);

  if (!(DATA_W == 32 || DATA_W == 64) || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_param_check
    $error("lsu_bus_ctrl: DATA_W must be 32/64 and MAX_WAIT 1..255");
  end

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [7:0] UOP_LB  = 8'h01, UOP_LBU = 8'h02, UOP_LH = 8'h03, UOP_LHU = 8'h04;
  localparam logic [7:0] UOP_LW  = 8'h05, UOP_LWU = 8'h06, UOP_LD = 8'h07;
  localparam logic [7:0] UOP_SB  = 8'h08, UOP_SH  = 8'h09, UOP_SW = 8'h0A, UOP_SD  = 8'h0B;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;

  localparam logic [31:0] EXC_LD_MIS = 32'h040, EXC_ST_MIS = 32'h020;
  localparam logic [31:0] EXC_LD_ACC = 32'h080, EXC_ST_ACC = 32'h100;

  logic [1:0]        state_q;
  logic              is_store_q, is_signed_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic [4:0]        rd_wa_q;
  logic [31:0]       exc_q;

  logic              dec_mem, dec_store, dec_signed, misaligned, timeout;
  logic [1:0]        dec_size;
  logic [OFF_W-1:0]  off;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] wdata_rep, rdata_shift, load_ext;
  logic              sign_bit;
  int                nbits;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    dec_mem    = 1'b1;
    dec_store  = 1'b0;
    dec_size   = 2'd0;
    dec_signed = 1'b0;
    case (uop_i)
      UOP_LB:  dec_signed = 1'b1;
      UOP_LBU: dec_size   = 2'd0;
      UOP_LH:  begin dec_size = 2'd1; dec_signed = 1'b1; end
      UOP_LHU: dec_size = 2'd1;
      UOP_LW:  begin dec_size = 2'd2; dec_signed = 1'b1; end
      UOP_LWU: begin dec_size = 2'd2; dec_mem = (DATA_W == 64); end
      UOP_LD:  begin dec_size = 2'd3; dec_signed = 1'b1; dec_mem = (DATA_W == 64); end
      UOP_SB:  dec_store = 1'b1;
      UOP_SH:  begin dec_store = 1'b1; dec_size = 2'd1; end
      UOP_SW:  begin dec_store = 1'b1; dec_size = 2'd2; end
      UOP_SD:  begin dec_store = 1'b1; dec_size = 2'd3; dec_mem = (DATA_W == 64); end
      default: dec_mem = 1'b0;
    endcase
    case (dec_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_i[0];
      2'd2:    misaligned = |addr_i[1:0];
      default: misaligned = |addr_i[2:0];
    endcase
  end

  // Lane mask and replicated store data; the access size decides the replication period.
  always_comb begin
    off       = addr_q[OFF_W-1:0];
    lane_mask = '0;
    wdata_rep = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i] = (i < (1 << size_q));
      case (size_q)
        2'd0:    wdata_rep[8*i +: 8] = wdata_q[7:0];
        2'd1:    wdata_rep[8*i +: 8] = wdata_q[8*(i%2) +: 8];
        2'd2:    wdata_rep[8*i +: 8] = wdata_q[8*(i%4) +: 8];
        default: wdata_rep[8*i +: 8] = wdata_q[8*(i%8) +: 8];
      endcase
    end
  end

  always_comb begin
    rdata_shift = bus_rdata_i >> {off, 3'b000};
    nbits       = 8 << size_q;
    case (size_q)
      2'd0:    sign_bit = rdata_shift[7];
      2'd1:    sign_bit = rdata_shift[15];
      2'd2:    sign_bit = rdata_shift[31];
      default: sign_bit = rdata_shift[DATA_W-1];
    endcase
    load_ext = '0;
    for (int i = 0; i < DATA_W; i++)
      load_ext[i] = (i < nbits) ? rdata_shift[i] : (is_signed_q & sign_bit);
  end

`ifdef LSU_BUS_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  assign timeout = (wait_cnt_q == 8'(MAX_WAIT - 1));

  // Counts consecutive cycles spent waiting for the current handshake; clears on handshake or timeout.
  always_ff @(posedge clk_i) begin
    if (!rs_n_i)
      wait_cnt_q <= '0;
    else if ((state_q == S_REQ && !bus_gnt_i) || (state_q == S_WAIT && !bus_rvalid_i))
      wait_cnt_q <= timeout ? '0 : wait_cnt_q + 8'd1;
    else
      wait_cnt_q <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    // NOTE: the request registers are few and feed outputs, so they are reset along with the FSM.
    if (!rs_n_i) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      is_signed_q <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_wa_q     <= '0;
      exc_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i && dec_mem) begin
          is_store_q  <= dec_store;
          is_signed_q <= dec_signed;
          size_q      <= dec_size;
          addr_q      <= addr_i;
          wdata_q     <= wdata_i;
          rd_wa_q     <= rd_wa_i;
          rdata_q     <= '0;
          if (misaligned) begin
            exc_q   <= dec_store ? EXC_ST_MIS : EXC_LD_MIS;
            state_q <= S_RESP;
          end else begin
            exc_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: if (bus_gnt_i) begin
          state_q <= S_WAIT;
        end else if (timeout) begin
          exc_q   <= is_store_q ? EXC_ST_ACC : EXC_LD_ACC;
          state_q <= S_RESP;
        end
        S_WAIT: if (bus_rvalid_i) begin
          rdata_q <= load_ext;
          if (bus_err_i) exc_q <= is_store_q ? EXC_ST_ACC : EXC_LD_ACC;
          state_q <= S_RESP;
        end else if (timeout) begin
          exc_q   <= is_store_q ? EXC_ST_ACC : EXC_LD_ACC;
          state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign stall_req_o = (state_q == S_REQ) || (state_q == S_WAIT);
  assign rsp_valid_o = (state_q == S_RESP);
  assign bus_req_o   = (state_q == S_REQ);
  assign bus_we_o    = bus_req_o && is_store_q;
  assign bus_addr_o  = bus_req_o ? {addr_q[DATA_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus_sel_o   = bus_req_o ? (lane_mask << off) : '0;
  assign bus_wdata_o = bus_req_o ? wdata_rep : '0;
  assign rd_we_o     = rsp_valid_o && !is_store_q && (exc_q == '0);
  assign rd_wa_o     = rsp_valid_o ? rd_wa_q : '0;
  assign rd_wd_o     = rd_we_o ? rdata_q : '0;
  assign exception_o = rsp_valid_o ? exc_q : '0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: a 32-bit instance (MAX_WAIT=4) and a 64-bit instance.
module tb_lsu_bus_ctrl;

  localparam logic [7:0] LB = 8'h01, LBU = 8'h02, LH = 8'h03, LHU = 8'h04, LW = 8'h05;
  localparam logic [7:0] LWU = 8'h06, LD = 8'h07, SB = 8'h08, SH = 8'h09, SW = 8'h0A;

  logic clk = 1'b0;
  logic rs_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, bus_req, bus_we, rsp_valid, rd_we, stall;
  logic [7:0]  uop;
  logic [31:0] addr, wdata, bus_addr, bus_wdata, bus_rdata, rd_wd, exception;
  logic [4:0]  rd_wa_in, rd_wa;
  logic [3:0]  bus_sel;
  logic        bus_gnt, bus_rvalid, bus_err;

  logic        req_valid64, req_ready64, bus_req64, bus_we64, rsp_valid64, rd_we64, stall64;
  logic [7:0]  uop64;
  logic [63:0] addr64, wdata64, bus_addr64, bus_wdata64, bus_rdata64, rd_wd64;
  logic [4:0]  rd_wa_in64, rd_wa64;
  logic [7:0]  bus_sel64;
  logic [31:0] exception64;

  lsu_bus_ctrl #(.DATA_W(32), .MAX_WAIT(4)) dut (
    .clk_i(clk), .rs_n_i(rs_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .uop_i(uop), .addr_i(addr), .wdata_i(wdata), .rd_wa_i(rd_wa_in),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_sel_o(bus_sel),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_err_i(bus_err),
    .bus_rdata_i(bus_rdata), .rsp_valid_o(rsp_valid), .rd_we_o(rd_we), .rd_wa_o(rd_wa),
    .rd_wd_o(rd_wd), .exception_o(exception), .stall_req_o(stall)
  );

  lsu_bus_ctrl #(.DATA_W(64), .MAX_WAIT(4)) dut64 (
    .clk_i(clk), .rs_n_i(rs_n), .req_valid_i(req_valid64), .req_ready_o(req_ready64),
    .uop_i(uop64), .addr_i(addr64), .wdata_i(wdata64), .rd_wa_i(rd_wa_in64),
    .bus_req_o(bus_req64), .bus_we_o(bus_we64), .bus_addr_o(bus_addr64), .bus_sel_o(bus_sel64),
    .bus_wdata_o(bus_wdata64), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_err_i(bus_err),
    .bus_rdata_i(bus_rdata64), .rsp_valid_o(rsp_valid64), .rd_we_o(rd_we64), .rd_wa_o(rd_wa64),
    .rd_wd_o(rd_wd64), .exception_o(exception64), .stall_req_o(stall64)
  );

  typedef struct {
    int          lat;
    logic        req;
    logic [3:0]  sel;
    logic [31:0] baddr;
    logic [31:0] bwd;
    logic        bwe;
    logic        we;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic [31:0] exc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Observed transaction, filled by issue()
  int          o_lat;
  logic        o_req, o_bwe, o_we;
  logic [3:0]  o_sel;
  logic [31:0] o_baddr, o_bwd, o_wd, o_exc;
  logic [4:0]  o_wa;

  task automatic issue(input logic [7:0] u, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] wa);
    req_valid = 1'b1; uop = u; addr = a; wdata = wd; rd_wa_in = wa;
    @(posedge clk); #1 req_valid = 1'b0;
    o_lat = -1; o_req = 0; o_sel = 0; o_baddr = 0; o_bwd = 0; o_bwe = 0;
    o_we = 0; o_wd = 0; o_wa = 0; o_exc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus_req) begin
        o_req = 1'b1; o_sel = bus_sel; o_baddr = bus_addr; o_bwd = bus_wdata; o_bwe = bus_we;
      end
      if (rsp_valid) begin
        o_lat = c; o_we = rd_we; o_wd = rd_wd; o_wa = rd_wa; o_exc = exception;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Pops the scoreboard head and compares the whole observed transaction against it.
  task automatic compare_txn(input string name);
    exp_t e;
    e = sb.pop_front();
    total++; if (o_lat !== e.lat) $display("FAIL %s latency: got %0d want %0d", name, o_lat, e.lat); else passed++;
    total++; if (o_req !== e.req) $display("FAIL %s bus_req: got %b want %b", name, o_req, e.req); else passed++;
    total++; if (o_sel !== e.sel) $display("FAIL %s bus_sel: got %b want %b", name, o_sel, e.sel); else passed++;
    total++; if (o_baddr !== e.baddr) $display("FAIL %s bus_addr: got %h want %h", name, o_baddr, e.baddr); else passed++;
    total++; if (o_bwe !== e.bwe) $display("FAIL %s bus_we: got %b want %b", name, o_bwe, e.bwe); else passed++;
    if (e.bwe) begin
      total++; if (o_bwd !== e.bwd) $display("FAIL %s bus_wdata: got %h want %h", name, o_bwd, e.bwd); else passed++;
    end
    total++; if (o_we !== e.we) $display("FAIL %s rd_we: got %b want %b", name, o_we, e.we); else passed++;
    total++; if (o_wd !== e.wd) $display("FAIL %s rd_wd: got %h want %h", name, o_wd, e.wd); else passed++;
    total++; if (o_wa !== e.wa) $display("FAIL %s rd_wa: got %0d want %0d", name, o_wa, e.wa); else passed++;
    total++; if (o_exc !== e.exc) $display("FAIL %s exception: got %h want %h", name, o_exc, e.exc); else passed++;
  endtask

  task automatic test_reset();
    rs_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b want 1", req_ready); else passed++;
    total++; if ({bus_req, bus_we, rsp_valid, rd_we, stall} !== 5'b0)
      $display("FAIL reset flags: got %b want 00000", {bus_req, bus_we, rsp_valid, rd_we, stall}); else passed++;
    total++; if ({bus_addr, bus_wdata, rd_wd, exception} !== 128'b0)
      $display("FAIL reset buses: got %h want 0", {bus_addr, bus_wdata, rd_wd, exception}); else passed++;
    @(posedge clk); #1 rs_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [7:0]  u_t[7] = '{LB, LBU, LH, LHU, LB, LW, LH};
    logic [31:0] a_t[7] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1004, 32'h1000};
    logic [31:0] r_t[7] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h1234_F00D,
                            32'h1234_F00D, 32'hDEAD_BEEF, 32'h0000_7ABC};
    logic [31:0] d_t[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_F00D,
                            32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'h0000_7ABC};
    logic [3:0]  s_t[7] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111, 4'b0011};
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_err = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus_rdata = r_t[i];
      sb.push_back('{lat: 3, req: 1'b1, sel: s_t[i], baddr: {a_t[i][31:2], 2'b00}, bwd: 32'h0,
                     bwe: 1'b0, we: 1'b1, wd: d_t[i], wa: 5'(i + 1), exc: 32'h0});
      issue(u_t[i], a_t[i], 32'h5555_5555, 5'(i + 1));
      compare_txn($sformatf("load%0d", i));
    end
  endtask

  task automatic test_stores();
    logic [7:0]  u_t[3] = '{SH, SB, SW};
    logic [31:0] a_t[3] = '{32'h2002, 32'h2001, 32'h2000};
    logic [31:0] w_t[3] = '{32'h0000_ABCD, 32'h1234_5677, 32'hCAFE_F00D};
    logic [31:0] r_t[3] = '{32'hABCD_ABCD, 32'h7777_7777, 32'hCAFE_F00D};
    logic [3:0]  s_t[3] = '{4'b1100, 4'b0010, 4'b1111};
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_err = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{lat: 3, req: 1'b1, sel: s_t[i], baddr: 32'h2000, bwd: r_t[i],
                     bwe: 1'b1, we: 1'b0, wd: 32'h0, wa: 5'd9, exc: 32'h0});
      issue(u_t[i], a_t[i], w_t[i], 5'd9);
      compare_txn($sformatf("store%0d", i));
    end
  endtask

  task automatic test_misaligned();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_err = 1'b0; bus_rdata = 32'h0;
    sb.push_back('{lat: 1, req: 1'b0, sel: 4'b0, baddr: 32'h0, bwd: 32'h0,
                   bwe: 1'b0, we: 1'b0, wd: 32'h0, wa: 5'd3, exc: 32'h040});
    issue(LW, 32'h3001, 32'h0, 5'd3);
    compare_txn("misaligned_lw");
    sb.push_back('{lat: 1, req: 1'b0, sel: 4'b0, baddr: 32'h0, bwd: 32'h0,
                   bwe: 1'b0, we: 1'b0, wd: 32'h0, wa: 5'd4, exc: 32'h020});
    issue(SH, 32'h2001, 32'h1234, 5'd4);
    compare_txn("misaligned_sh");
  endtask

  task automatic test_bus_err();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1111_2222;
    sb.push_back('{lat: 3, req: 1'b1, sel: 4'b1111, baddr: 32'h7000, bwd: 32'h0,
                   bwe: 1'b0, we: 1'b0, wd: 32'h0, wa: 5'd6, exc: 32'h080});
    issue(LW, 32'h7000, 32'h0, 5'd6);
    compare_txn("err_lw");
    sb.push_back('{lat: 3, req: 1'b1, sel: 4'b0001, baddr: 32'h7004, bwd: 32'h5A5A_5A5A,
                   bwe: 1'b1, we: 1'b0, wd: 32'h0, wa: 5'd6, exc: 32'h100});
    issue(SB, 32'h7004, 32'h0000_005A, 5'd6);
    compare_txn("err_sb");
    bus_err = 1'b0;
  endtask

  task automatic test_non_mem();
    logic [7:0] u_t[2] = '{8'h00, LD};
    logic       ok;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; uop = u_t[i]; addr = 32'h8000;
      @(posedge clk); #1 req_valid = 1'b0;
      ok = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (req_ready !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0 || rsp_valid !== 1'b0) ok = 1'b0;
      end
      total++; if (ok !== 1'b1) $display("FAIL non_mem%0d ignored: got %b want 1", i, ok); else passed++;
    end
  endtask

  task automatic test_timeout();
    bus_gnt = 1'b1; bus_rvalid = 1'b0; bus_err = 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
    sb.push_back('{lat: 6, req: 1'b1, sel: 4'b1111, baddr: 32'h5000, bwd: 32'h0BAD_F00D,
                   bwe: 1'b1, we: 1'b0, wd: 32'h0, wa: 5'd2, exc: 32'h100});
    issue(SW, 32'h5000, 32'h0BAD_F00D, 5'd2);
    compare_txn("timeout_sw");
`else
    begin
      logic ok;
      req_valid = 1'b1; uop = SW; addr = 32'h5000; wdata = 32'h0BAD_F00D;
      @(posedge clk); #1 req_valid = 1'b0;
      ok = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (stall !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
      end
      total++; if (ok !== 1'b1) $display("FAIL no_timeout stall held: got %b want 1", ok); else passed++;
      rs_n = 1'b0;
      @(posedge clk); #1 rs_n = 1'b1;
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic ok;
    bus_gnt = 1'b1; bus_rvalid = 1'b0; bus_err = 1'b0;
    req_valid = 1'b1; uop = LW; addr = 32'h6000;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (stall !== 1'b1 || bus_req !== 1'b0)
      $display("FAIL reset_mid in WAIT: got stall=%b bus_req=%b want 1 0", stall, bus_req); else passed++;
    rs_n = 1'b0;
    @(posedge clk); #1 rs_n = 1'b1; bus_rvalid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rd_we !== 1'b0) ok = 1'b0;
    end
    total++; if (ok !== 1'b1) $display("FAIL reset_mid abandoned: got %b want 1", ok); else passed++;
    @(posedge clk); #1 bus_rvalid = 1'b0;
  endtask

  task automatic test_dw64();
    logic [7:0]  u_t[2] = '{LWU, LW};
    logic [63:0] d_t[2] = '{64'h0000_0000_F234_5678, 64'hFFFF_FFFF_F234_5678};
    int          lat;
    logic [7:0]  sel;
    logic [63:0] wd;
    logic        we;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_err = 1'b0;
    bus_rdata64 = 64'hF234_5678_0000_0000;
    for (int i = 0; i < 2; i++) begin
      req_valid64 = 1'b1; uop64 = u_t[i]; addr64 = 64'h4004; rd_wa_in64 = 5'd7;
      @(posedge clk); #1 req_valid64 = 1'b0;
      lat = -1; sel = 0; wd = 0; we = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (bus_req64) sel = bus_sel64;
        if (rsp_valid64) begin lat = c; wd = rd_wd64; we = rd_we64; break; end
      end
      @(posedge clk); #1;
      total++; if (lat !== 3) $display("FAIL dw64_%0d latency: got %0d want 3", i, lat); else passed++;
      total++; if (sel !== 8'hF0) $display("FAIL dw64_%0d bus_sel: got %h want f0", i, sel); else passed++;
      total++; if (we !== 1'b1) $display("FAIL dw64_%0d rd_we: got %b want 1", i, we); else passed++;
      total++; if (wd !== d_t[i]) $display("FAIL dw64_%0d rd_wd: got %h want %h", i, wd, d_t[i]); else passed++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req_valid = 0; uop = 0; addr = 0; wdata = 0; rd_wa_in = 0;
    req_valid64 = 0; uop64 = 0; addr64 = 0; wdata64 = 0; rd_wa_in64 = 0; bus_rdata64 = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_bus_err();
    test_non_mem();
    test_timeout();
    test_reset_mid();
    test_dw64();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 Parameter DATA_W, 32, bus/data width in bits; legal values 32 or 64.
REQ-002 Parameter MAX_WAIT, 15, maximum bus wait cycles before an access fault; range 1..255.
REQ-003 Port clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port rs_n_i  in  1  reset; synchronous and active-low.
REQ-005 Port req_valid_i  in  1  LSU request from EX; req_ready_o  out  1  request accepted.
REQ-006 Port uop_i  in  `AluOpBus  uop (LB/LBU/LH/LHU/LW/LWU/LD/SB/SH/SW/SD); addr_i  in  DATA_W  effective address; wdata_i  in  DATA_W  store data; rd_wa_i  in  `REG_BUS_A  load destination.
REQ-007 Port bus_req_o  out  1; bus_we_o  out  1; bus_addr_o  out  DATA_W (lane-aligned); bus_sel_o  out  DATA_W/8; bus_wdata_o  out  DATA_W.
REQ-008 Port bus_gnt_i  in  1; bus_rvalid_i  in  1; bus_err_i  in  1 (qualified by rvalid); bus_rdata_i  in  DATA_W.
REQ-009 Port rsp_valid_o  out  1; rd_we_o  out  1; rd_wa_o  out  `REG_BUS_A; rd_wd_o  out  DATA_W; exception_o  out  `REG_BUS_D; stall_req_o  out  1.

Function
REQ-010 FSM states: IDLE, REQ, WAIT, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-011 IDLE: on req_valid_i with a memory uop, the request (uop, address, data, rd_wa) SHALL be registered; aligned -> REQ, misaligned -> RESP without bus activity.
REQ-012 Non-memory uop with req_valid_i SHALL be ignored; FSM stays in IDLE.
REQ-013 Alignment: halfword needs addr[0]=0, word addr[1:0]=0, doubleword addr[2:0]=0; LWU/LD/SD are legal only when DATA_W=64, otherwise treated as non-memory uops.
REQ-014 REQ: bus_req_o=1 and address/sel/wdata/we held stable until bus_gnt_i; on grant -> WAIT.
REQ-015 WAIT: on bus_rvalid_i -> RESP; load data captured from bus_rdata_i in the same cycle.
REQ-016 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; minimum aligned latency is accept + 3 cycles with zero-wait grant and rvalid.
REQ-017 Byte lanes are little-endian: byte at offset k uses sel bit k and data[8k+7:8k]; store data SHALL be replicated across all lanes.
REQ-018 Loads: selected lane(s) extracted and sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to DATA_W; rd_we_o=1 in RESP only for a fault-free load.
REQ-019 exception_o bit 6 = load misaligned, bit 5 = store misaligned, bit 7 = load access fault, bit 8 = store access fault; all other bits 0; valid only while rsp_valid_o=1, else 0.
REQ-020 bus_err_i with bus_rvalid_i SHALL raise the matching access fault; rd_we_o=0.
REQ-021 stall_req_o SHALL be 1 in REQ and WAIT, and 0 otherwise.
REQ-022 bus_req_o SHALL never assert for a misaligned access; bus_we_o=1 only for stores in REQ.

Reset
REQ-023 While rs_n_i=0 at a clock edge: state=IDLE, wait counter=0, all outputs 0 except req_ready_o=1.
REQ-024 Reset mid-transaction SHALL abandon the access; a later bus_rvalid_i for it is ignored in IDLE.

Configuration
REQ-025 Macro LSU_BUS_TIMEOUT_EN defined: a counter increments each cycle in REQ and WAIT; when it reaches MAX_WAIT without the awaited handshake, the FSM enters RESP with the matching access fault and the counter clears.
REQ-026 Macro LSU_BUS_TIMEOUT_EN undefined: no counter; REQ and WAIT wait indefinitely; MAX_WAIT is unused.

Verification
REQ-027 DATA_W=32, LB addr 0x1003, rdata 0x80FF_0000, gnt and rvalid immediate -> bus_sel_o=4'b1000, rd_wd_o=0xFFFF_FF80, rsp_valid_o at accept+3.
REQ-028 SH addr 0x2002, wdata 0x0000_ABCD -> bus_sel_o=4'b1100, bus_wdata_o=0xABCD_ABCD, bus_we_o=1, rd_we_o=0.
REQ-029 LW addr 0x3001 -> no bus_req_o, rsp_valid_o one cycle after accept, exception_o=0x40, rd_we_o=0.
REQ-030 With LSU_BUS_TIMEOUT_EN and MAX_WAIT=4, SW with gnt but no rvalid -> exception_o=0x100 after 4 WAIT-related cycles; with the macro undefined, stall_req_o stays 1 indefinitely.
REQ-031 DATA_W=64, LWU addr 0x4004, rdata 0xF234_5678_0000_0000 -> bus_sel_o=8'hF0, rd_wd_o=0x0000_0000_F234_5678.
REQ-032 Assert rs_n_i=0 during WAIT, then rvalid after release -> state IDLE, rsp_valid_o stays 0.
